ssc_muldiv_unit: RTL and testbench

Multi-cycle unsigned multiply/divide unit sitting directly downstream of the SSC register bank. Consumes the bank's two operand read ports (`OutA`, `OutB`) and returns a result on the bank's write-back path (`WBDataIN`, `wEnable`, `DestReg`) and flag path (`BRFlags`, `SetFlags`). While an operation runs it raises `Stall`; top level gates the bank's `Clk_Enable` and the PC with this signal so operands and instruction stay frozen.

---
 rtl/ssc_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_ssc_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ssc_muldiv_unit.sv
// ssc_muldiv_unit: 32-cycle shift-add multiplier / restoring divider.
// Optional signed mode: define SSC_MULDIV_SIGNED_EN.
module ssc_muldiv_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic        Signed,
  input  logic        FlagEn,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [2:0]  DestIn,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic        wEnableOut,
  output logic [2:0]  DestOut,
  output logic [31:0] Result,
  output logic [3:0]  BRFlagsOut,
  output logic        SetFlagsOut
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic        flag_en_q;
  logic [31:0] opnd_a, opnd_b;
  logic [31:0] acc_hi, acc_lo;
  logic [31:0] a_in, b_in;
  logic        accept, dbz, last;

  assign accept = Start & (state == IDLE | state == DONE);
  assign dbz    = Op[1] & (OpB == 32'd0);
  assign last   = (state == RUN) & (cnt == 5'd31);

`ifdef SSC_MULDIV_SIGNED_EN
  logic neg_a, neg_b, neg_q, neg_r, sgn_q;
  assign neg_a = Signed & OpA[31];
  assign neg_b = Signed & OpB[31];
  assign a_in  = neg_a ? -OpA : OpA;
  assign b_in  = neg_b ? -OpB : OpB;

  // sign-correction controls captured with the operands
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      sgn_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      sgn_q <= Signed;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign a_in = OpA;
  assign b_in = OpB;
`endif

  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = Start ? (dbz ? DONE : RUN) : IDLE;
      RUN:        if (cnt == 5'd31) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign Busy        = (state != IDLE);
  assign Stall       = (state == IDLE & Start) | (state == RUN);
  assign Done        = (state == DONE);
  assign wEnableOut  = Done;
  assign SetFlagsOut = Done & flag_en_q;

  logic [32:0] sum, shl;
  logic [31:0] diff;
  logic        ge;
  logic [31:0] hi_nxt, lo_nxt;

  // one multiply or divide iteration
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_a} : 33'd0);
    shl  = {acc_hi, acc_lo[31]};
    ge   = (shl >= {1'b0, opnd_b});
    diff = shl[31:0] - opnd_b;
    if (op_q[1]) begin
      hi_nxt = ge ? diff : shl[31:0];
      lo_nxt = {acc_lo[30:0], ge};
    end else begin
      hi_nxt = sum[32:1];
      lo_nxt = {sum[0], acc_lo[31:1]};
    end
  end

  logic [63:0] prod;
  logic [63:0] ext;
  logic [31:0] quo, rem, res_fin, dbz_res;
  logic        c_fin;

  // final result selection and flag terms
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    quo  = lo_nxt;
    rem  = hi_nxt;
    ext  = 64'd0;
`ifdef SSC_MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_r) rem = -rem;
    if (sgn_q) ext = {32'd0, {32{prod[31]}}};
`endif
    unique case (op_q)
      2'b00:   res_fin = prod[31:0];
      2'b01:   res_fin = prod[63:32];
      2'b10:   res_fin = quo;
      default: res_fin = rem;
    endcase
    c_fin   = (op_q == 2'b00) & (prod[63:32] != ext[31:0]);
    dbz_res = Op[0] ? OpA : 32'hFFFF_FFFF;
  end

  // operand capture, iteration and result write-back
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt        <= 5'd0;
      op_q       <= 2'd0;
      flag_en_q  <= 1'b0;
      opnd_a     <= 32'd0;
      opnd_b     <= 32'd0;
      acc_hi     <= 32'd0;
      acc_lo     <= 32'd0;
      DestOut    <= 3'd0;
      Result     <= 32'd0;
      BRFlagsOut <= 4'd0;
    end else if (accept) begin
      cnt       <= 5'd0;
      op_q      <= Op;
      flag_en_q <= FlagEn;
      opnd_a    <= a_in;
      opnd_b    <= b_in;
      acc_hi    <= 32'd0;
      acc_lo    <= Op[1] ? a_in : b_in;
      DestOut   <= DestIn;
      if (dbz) begin
        Result     <= dbz_res;
        BRFlagsOut <= {dbz_res[31], dbz_res == 32'd0, 1'b0, 1'b1};
      end
    end else if (state == RUN) begin
      cnt    <= cnt + 5'd1;
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      if (last) begin
        Result     <= res_fin;
        BRFlagsOut <= {res_fin[31], res_fin == 32'd0, c_fin, 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_ssc_muldiv_unit.sv
// tb_ssc_muldiv_unit: randomized + directed check of ssc_muldiv_unit
// against an arithmetic reference model.
module tb_ssc_muldiv_unit;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic        Signed = 1'b0;
  logic        FlagEn = 1'b0;
  logic [31:0] OpA = 32'd0;
  logic [31:0] OpB = 32'd0;
  logic [2:0]  DestIn = 3'd0;
  logic        Busy, Stall, Done, wEnableOut, SetFlagsOut;
  logic [2:0]  DestOut;
  logic [31:0] Result;
  logic [3:0]  BRFlagsOut;

  int n_tests = 0;
  int n_fail  = 0;

  ssc_muldiv_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .Signed(Signed), .FlagEn(FlagEn), .OpA(OpA), .OpB(OpB),
    .DestIn(DestIn), .Busy(Busy), .Stall(Stall), .Done(Done),
    .wEnableOut(wEnableOut), .DestOut(DestOut), .Result(Result),
    .BRFlagsOut(BRFlagsOut), .SetFlagsOut(SetFlagsOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sgn,
                       output logic [31:0] r, output logic [3:0] f);
    logic [63:0] p, q, m;
    longint sa, sb;
    logic c, v, sm;
    sm = 1'b0;
`ifdef SSC_MULDIV_SIGNED_EN
    sm = sgn;
`endif
    c = 1'b0;
    v = 1'b0;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p = sa * sb;
    if (b == 32'd0) begin
      q = 64'hFFFF_FFFF;
      m = {32'd0, a};
      v = 1'b1;
    end else begin
      q = sa / sb;
      m = sa % sb;
    end
    case (op)
      2'b00: begin
        r = p[31:0];
        c = sm ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'd0);
      end
      2'b01:   r = p[63:32];
      2'b10:   r = q[31:0];
      default: r = m[31:0];
    endcase
    if (!op[1]) v = 1'b0;
    f = {r[31], r == 32'd0, c, v};
  endtask

  task automatic wait_done(input bit poke, output int lat);
    lat = 0;
    while (!Done && lat < 40) begin
      chk("stall_run", Stall, 1);
      if (poke) Start = (lat >= 5 && lat <= 8);
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sgn,
                       input logic [2:0] dest, input logic fe);
    int lat;
    logic [31:0] er;
    logic [3:0]  ef;
    @(negedge Clk);
    Op = op; OpA = a; OpB = b; Signed = sgn;
    DestIn = dest; FlagEn = fe; Start = 1'b1;
    #1 chk("stall_req", Stall, 1);
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(1'b0, lat);
    model(op, a, b, sgn, er, ef);
    chk("latency", lat, (op[1] && b == 0) ? 0 : 32);
    chk("result", Result, er);
    chk("flags", BRFlagsOut, ef);
    chk("dest", DestOut, dest);
    chk("wen", wEnableOut, 1);
    chk("setflags", SetFlagsOut, fe);
    chk("stall_done", Stall, 0);
    @(posedge Clk);
    #1;
    chk("done_drop", Done, 0);
    chk("idle", Busy, 0);
  endtask

  initial begin
    int lat, dc;
    logic [1:0]  op;
    logic [31:0] a, b;
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_flags", BRFlagsOut, 0);
    chk("rst_dest", DestOut, 0);
    @(negedge Clk) Rst_n = 1'b1;

    do_op(2'b00, 32'h0000FFFF, 32'h0000FFFF, 0, 3'd1, 1);
    do_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 0, 3'd2, 1);
    do_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 0, 3'd2, 0);
    do_op(2'b10, 32'd100, 32'd7, 0, 3'b101, 1);
    do_op(2'b11, 32'd100, 32'd7, 0, 3'b101, 1);
    do_op(2'b11, 32'd21, 32'd7, 0, 3'd6, 1);
    do_op(2'b10, 32'h1234, 32'd0, 0, 3'd3, 1);
    do_op(2'b11, 32'h1234, 32'd0, 0, 3'd4, 1);

    // reset part-way through a run
    @(negedge Clk);
    Op = 2'b00; OpA = 32'd9; OpB = 32'd9; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk) Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_result", Result, 0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    dc = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) dc++;
    end
    chk("mid_rst_nodone", dc, 0);
    do_op(2'b00, 32'd3, 32'd5, 0, 3'd7, 1);

    // back-to-back: Start held through DONE
    @(negedge Clk);
    Op = 2'b00; OpA = 32'd7; OpB = 32'd9; Signed = 1'b0;
    DestIn = 3'd2; FlagEn = 1'b1; Start = 1'b1;
    @(posedge Clk);
    #1;
    wait_done(1'b0, lat);
    chk("b2b_lat1", lat, 32);
    chk("b2b_res1", Result, 63);
    Op = 2'b10; OpA = 32'd100; OpB = 32'd7; DestIn = 3'd5;
    @(posedge Clk);
    #1 Start = 1'b0;
    chk("b2b_run", Done, 0);
    chk("b2b_busy", Busy, 1);
    wait_done(1'b1, lat);
    Start = 1'b0;
    chk("b2b_lat2", lat, 32);
    chk("b2b_res2", Result, 14);
    chk("b2b_dest2", DestOut, 5);
    @(posedge Clk);
    #1 chk("b2b_idle", Busy, 0);

`ifdef SSC_MULDIV_SIGNED_EN
    do_op(2'b10, -32'sd7, 32'd2, 1, 3'd1, 1);
    do_op(2'b11, -32'sd7, 32'd2, 1, 3'd1, 1);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 3'd1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      do_op(op, a, b, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
